// File: rtl/video_defs.sv
// Shared video definitions for the scandoubler: colour width, RGB packing
// width and scanline dimming mode codes.
package video_defs;

  localparam int COLOR_W = 6;
  localparam int RGB_W   = 3 * COLOR_W;

  typedef enum logic [1:0] {
    SL_OFF = 2'd0,
    SL_25  = 2'd1,
    SL_50  = 2'd2,
    SL_75  = 2'd3
  } sl_mode_e;

endpackage

// File: rtl/scandoubler_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, bank bit is the address MSB.
// Read data is registered (1-cycle latency) and only updates when re is high.
module scandoubler_linebuf #(
  parameter int AW = 11,
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_data_q <= mem[raddr];
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/scandoubler.sv
// Line doubler: buffers each 15 kHz input line and replays the previous one
// twice at the doubled pixel rate, with regenerated syncs and scanline dimming.
module scandoubler #(
  parameter int HCNT_W  = 10,
  parameter int COLOR_W = video_defs::COLOR_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce_x1,
  input  logic               ce_x2,
  input  logic [1:0]         scanlines,
  input  logic               hs_in,
  input  logic               vs_in,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic               hs_out,
  output logic               vs_out,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out
);
  import video_defs::*;

  localparam int PIX_W = 3 * COLOR_W;
  localparam logic [HCNT_W-1:0] ADDR_MAX = '1;
  localparam logic [HCNT_W-1:0] ONE      = {{(HCNT_W-1){1'b0}}, 1'b1};

  function automatic logic [COLOR_W-1:0] dim(input logic [COLOR_W-1:0] c,
                                             input logic [1:0]         s);
    case (sl_mode_e'(s))
      SL_25:   dim = c - (c >> 2);
      SL_50:   dim = c >> 1;
      SL_75:   dim = c >> 2;
      default: dim = c;
    endcase
  endfunction

  logic              hs_prev_q, hs_prev_d;
  logic              wr_bank_q, wr_bank_d;
  logic [HCNT_W-1:0] wr_addr_q, wr_addr_d;
  logic [HCNT_W-1:0] hs_cnt_q, hs_cnt_d;
  logic [HCNT_W-1:0] hs_cap_q, hs_cap_d;
  logic [HCNT_W-1:0] hs_len_q, hs_len_d;
  logic [HCNT_W-1:0] line_len_q, line_len_d;
  logic [HCNT_W-1:0] rd_addr_q, rd_addr_d;
  logic              out_line_q, out_line_d;
  logic              vs_next_q, vs_next_d;
  logic              vld_p1_q, vld_p1_d;
  logic              hs_out_q, hs_out_d;
  logic              vs_out_q, vs_out_d;
  logic [COLOR_W-1:0] r_out_q, r_out_d, g_out_q, g_out_d, b_out_q, b_out_d;

  logic              hs_rise, hs_fall, restart, rd_en;
  logic [PIX_W-1:0]  rd_data_p1;

  assign hs_rise = ce_x1 & hs_in & ~hs_prev_q;
  assign hs_fall = ce_x1 & ~hs_in & hs_prev_q;
  assign restart = hs_rise;
  assign rd_en   = ce_x2 | restart;

  // Input side: write counter, hsync width measurement, bank swap
  always_comb begin
    hs_prev_d  = hs_prev_q;
    wr_addr_d  = wr_addr_q;
    wr_bank_d  = wr_bank_q;
    hs_cnt_d   = hs_cnt_q;
    hs_cap_d   = hs_cap_q;
    hs_len_d   = hs_len_q;
    line_len_d = line_len_q;
    if (ce_x1) begin
      hs_prev_d = hs_in;
      wr_addr_d = (wr_addr_q == ADDR_MAX) ? ADDR_MAX : wr_addr_q + ONE;
      if (hs_fall) begin
        hs_cnt_d = '0;
        hs_cap_d = hs_cnt_q;
      end else if (hs_in) begin
        hs_cnt_d = (hs_cnt_q == ADDR_MAX) ? ADDR_MAX : hs_cnt_q + ONE;
      end
      if (hs_rise) begin
        line_len_d = (wr_addr_q == ADDR_MAX) ? ADDR_MAX : wr_addr_q + ONE;
        hs_len_d   = hs_cap_q;
        wr_addr_d  = '0;
        wr_bank_d  = ~wr_bank_q;
      end
    end
  end

  // Stage p0: read address; restart re-points to the bank just completed
  always_comb begin
    rd_addr_d  = rd_addr_q;
    out_line_d = out_line_q;
    vs_next_d  = vs_next_q;
    if (restart) begin
      rd_addr_d  = '0;
      out_line_d = 1'b0;
      vs_next_d  = vs_in;
    end else if (ce_x2) begin
      if (rd_addr_q == line_len_q - ONE) begin
        rd_addr_d  = '0;
        out_line_d = 1'b1;
      end else begin
        rd_addr_d = rd_addr_q + ONE;
      end
    end
  end

  scandoubler_linebuf #(
    .AW(HCNT_W + 1),
    .DW(PIX_W)
  ) u_linebuf (
    .clk   (clk),
    .we    (ce_x1),
    .waddr ({wr_bank_q, wr_addr_q}),
    .wdata ({r_in, g_in, b_in}),
    .re    (rd_en),
    .raddr ({~wr_bank_d, rd_addr_d}),
    .rdata (rd_data_p1)
  );

  // Stage p1 -> p2: RAM data valid, register dimmed colour and syncs
  always_comb begin
    vld_p1_d = rd_en;
    hs_out_d = hs_out_q;
    vs_out_d = vs_out_q;
    r_out_d  = r_out_q;
    g_out_d  = g_out_q;
    b_out_d  = b_out_q;
    if (vld_p1_q) begin
      hs_out_d = (rd_addr_q < hs_len_q);
      vs_out_d = vs_next_q;
      r_out_d  = rd_data_p1[3*COLOR_W-1:2*COLOR_W];
      g_out_d  = rd_data_p1[2*COLOR_W-1:COLOR_W];
      b_out_d  = rd_data_p1[COLOR_W-1:0];
      if (out_line_q) begin
        r_out_d = dim(rd_data_p1[3*COLOR_W-1:2*COLOR_W], scanlines);
        g_out_d = dim(rd_data_p1[2*COLOR_W-1:COLOR_W], scanlines);
        b_out_d = dim(rd_data_p1[COLOR_W-1:0], scanlines);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_prev_q  <= 1'b0;
      wr_bank_q  <= 1'b0;
      wr_addr_q  <= '0;
      hs_cnt_q   <= '0;
      hs_cap_q   <= '0;
      hs_len_q   <= '0;
      line_len_q <= '0;
      rd_addr_q  <= '0;
      out_line_q <= 1'b0;
      vs_next_q  <= 1'b0;
      vld_p1_q   <= 1'b0;
      hs_out_q   <= 1'b0;
      vs_out_q   <= 1'b0;
      r_out_q    <= '0;
      g_out_q    <= '0;
      b_out_q    <= '0;
    end else begin
      hs_prev_q  <= hs_prev_d;
      wr_bank_q  <= wr_bank_d;
      wr_addr_q  <= wr_addr_d;
      hs_cnt_q   <= hs_cnt_d;
      hs_cap_q   <= hs_cap_d;
      hs_len_q   <= hs_len_d;
      line_len_q <= line_len_d;
      rd_addr_q  <= rd_addr_d;
      out_line_q <= out_line_d;
      vs_next_q  <= vs_next_d;
      vld_p1_q   <= vld_p1_d;
      hs_out_q   <= hs_out_d;
      vs_out_q   <= vs_out_d;
      r_out_q    <= r_out_d;
      g_out_q    <= g_out_d;
      b_out_q    <= b_out_d;
    end
  end

  assign hs_out = hs_out_q;
  assign vs_out = vs_out_q;
  assign r_out  = r_out_q;
  assign g_out  = g_out_q;
  assign b_out  = b_out_q;

endmodule

// File: tb/tb_scandoubler.sv
// Directed bench for scandoubler with a line-level reference model checked on
// every clock, plus hand-computed spot values.
`timescale 1ns/1ps
module tb_scandoubler;

  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          ce_x1 = 1'b0, ce_x2 = 1'b0;
  logic [1:0]    scanlines = 2'd0;
  logic          hs_in = 1'b0, vs_in = 1'b0;
  logic [CW-1:0] r_in = '0, g_in = '0, b_in = '0;
  logic          hs_out, vs_out;
  logic [CW-1:0] r_out, g_out, b_out;

  scandoubler #(.HCNT_W(10), .COLOR_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .ce_x1(ce_x1), .ce_x2(ce_x2),
    .scanlines(scanlines), .hs_in(hs_in), .vs_in(vs_in),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .hs_out(hs_out), .vs_out(vs_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out)
  );

  always #15.625 clk = ~clk;

  initial begin
    #2500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: input lines as sample arrays, output as position
  // counted in output pixels since the last line start.
  int cur[1024];
  int ln[1024];
  int cnt, ln_len, hs_len_m, run_m, last_run, k_m, sl_prev;
  bit hs_prev_m, started, ln_ok, vs_m;
  bit pv0, pv1, pc0, pc1, pol0, pol1, phs0, phs1, pvs0, pvs1;
  int pr0, pr1, pg0, pg1, pb0, pb1;
  int e_r, e_g, e_b;
  bit e_hs, e_vs, e_c;

  function automatic int dimf(input int c, input bit ol, input int s);
    if (!ol) return c;
    case (s)
      1: return c - c / 4;
      2: return c / 2;
      3: return c / 4;
      default: return c;
    endcase
  endfunction

  task automatic m_reset();
    cnt = 0; ln_len = 0; hs_len_m = 0; run_m = 0; last_run = 0; k_m = 0;
    hs_prev_m = 0; started = 0; ln_ok = 0; vs_m = 0;
    pv0 = 0; pv1 = 0; pc0 = 0; pc1 = 0;
    e_r = 0; e_g = 0; e_b = 0; e_hs = 0; e_vs = 0; e_c = 0;
  endtask

  task automatic model_step();
    bit rs;
    int addr, px;
    if (!reset_n) begin
      m_reset();
      chk("reset_r_out", int'(r_out), 0);
      chk("reset_g_out", int'(g_out), 0);
      chk("reset_b_out", int'(b_out), 0);
      chk("reset_hs_out", int'(hs_out), 0);
      chk("reset_vs_out", int'(vs_out), 0);
    end else begin
      if (pv1) begin
        e_r = dimf(pr1, pol1, sl_prev);
        e_g = dimf(pg1, pol1, sl_prev);
        e_b = dimf(pb1, pol1, sl_prev);
        e_hs = phs1; e_vs = pvs1; e_c = pc1;
      end
      if (e_c) begin
        chk("pix_r", int'(r_out), e_r);
        chk("pix_g", int'(g_out), e_g);
        chk("pix_b", int'(b_out), e_b);
        chk("pix_hs", int'(hs_out), int'(e_hs));
        chk("pix_vs", int'(vs_out), int'(e_vs));
      end
      pv1 = pv0; pc1 = pc0; pol1 = pol0; phs1 = phs0; pvs1 = pvs0;
      pr1 = pr0; pg1 = pg0; pb1 = pb0;
      pv0 = 0;
      rs = 0;
      if (ce_x1) begin
        px = {r_in, g_in, b_in};
        cur[(cnt > 1023) ? 1023 : cnt] = px;
        cnt++;
        if (hs_in && !hs_prev_m) begin
          rs = 1;
          for (int i = 0; i < 1024; i++) ln[i] = cur[i];
          ln_len = (cnt > 1023) ? 1023 : cnt;
          ln_ok = started;
          started = 1;
          cnt = 0;
          hs_len_m = last_run;
          vs_m = vs_in;
          k_m = 0;
        end
        if (!hs_in && hs_prev_m) begin
          last_run = run_m;
          run_m = 0;
        end else if (hs_in) begin
          run_m++;
        end
        hs_prev_m = hs_in;
      end
      if (rs || ce_x2) begin
        if (!rs) k_m++;
        pv0 = 1;
        pc0 = ln_ok;
        if (ln_ok) begin
          addr = k_m % ln_len;
          pol0 = (k_m >= ln_len);
          pr0 = (ln[addr] >> (2 * CW)) & 63;
          pg0 = (ln[addr] >> CW) & 63;
          pb0 = ln[addr] & 63;
          phs0 = (addr < hs_len_m);
          pvs0 = vs_m;
        end
      end
    end
    sl_prev = int'(scanlines);
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input bit h, input bit v, input int r, input int g, input int b);
    hs_in = h; vs_in = v;
    r_in = CW'(r); g_in = CW'(g); b_in = CW'(b);
    ce_x1 = 1'b1; ce_x2 = 1'b1; tick();
    ce_x1 = 1'b0; ce_x2 = 1'b0; tick();
    ce_x2 = 1'b1; tick();
    ce_x2 = 1'b0; tick();
  endtask

  // mode 0: ramp, mode 1: constant 60
  task automatic send_range(input int hsw, input int mode, input int from, input int to,
                            input int vs_from);
    for (int i = from; i < to; i++) begin
      if (mode == 0) pix(i < hsw, i >= vs_from, i % 64, (3 * i) % 64, 63 - (i % 64));
      else           pix(i < hsw, i >= vs_from, 60, 60, 60);
    end
  endtask

  task automatic send_line(input int len, input int hsw, input int mode, input int vs_from);
    send_range(hsw, mode, 0, len, vs_from);
  endtask

  localparam int NEVER = 1 << 20;

  initial begin
    int dimexp[4];
    dimexp[0] = 60; dimexp[1] = 45; dimexp[2] = 30; dimexp[3] = 15;
    m_reset();
    sl_prev = 0;
    repeat (2) @(posedge clk);
    #1;
    repeat (3) tick();
    chk("rst_wr_addr", int'(dut.wr_addr_q), 0);
    chk("rst_line_len", int'(dut.line_len_q), 0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Basic doubling: 640 active + 64 sync = 704 samples per line
    repeat (3) send_line(704, 64, 0, NEVER);
    chk("basic_line_len", int'(dut.line_len_q), 704);
    chk("basic_hs_len", int'(dut.hs_len_q), 64);
    send_range(64, 0, 0, 10, NEVER);
    chk("basic_hs_high", int'(hs_out), 1);
    chk("basic_r_at_k19", int'(r_out), 20);
    send_range(64, 0, 10, 40, NEVER);
    chk("basic_hs_low", int'(hs_out), 0);
    send_range(64, 0, 40, 100, NEVER);
    chk("basic_r_at_k199", int'(r_out), 8);
    chk("basic_g_at_k199", int'(g_out), 24);
    send_range(64, 0, 100, 704, NEVER);

    // Scanlines on constant colour 60; also restart colliding with wrap
    for (int s = 1; s < 4; s++) begin
      scanlines = 2'(s);
      repeat (3) send_line(100, 8, 1, NEVER);
      chk("wrap_rd_addr_before", int'(dut.rd_addr_q), 99);
      chk("wrap_out_line_before", int'(dut.out_line_q), 1);
      send_range(8, 1, 0, 1, NEVER);
      chk("restart_rd_addr", int'(dut.rd_addr_q), 1);
      chk("restart_out_line", int'(dut.out_line_q), 0);
      send_range(8, 1, 1, 10, NEVER);
      chk("sl_even_r", int'(r_out), 60);
      send_range(8, 1, 10, 80, NEVER);
      chk("sl_odd_r", int'(r_out), dimexp[s]);
      chk("sl_odd_b", int'(b_out), dimexp[s]);
      send_range(8, 1, 80, 100, NEVER);
    end
    scanlines = 2'd0;

    // vsync rising mid-line is retimed to the next output line start
    send_line(100, 8, 0, NEVER);
    send_range(8, 0, 0, 60, 50);
    chk("vs_not_yet", int'(vs_out), 0);
    send_range(8, 0, 60, 100, 50);
    send_range(8, 0, 0, 1, 0);
    chk("vs_at_restart", int'(vs_out), 1);
    send_range(8, 0, 1, 100, 0);
    send_line(100, 8, 0, NEVER);
    send_line(100, 8, 0, NEVER);

    // Overflow: 1100-sample line saturates at the last buffer entry
    send_line(704, 64, 0, NEVER);
    send_line(1100, 64, 0, NEVER);
    chk("ovf_wr_addr", int'(dut.wr_addr_q), 1023);
    send_range(64, 0, 0, 10, NEVER);
    chk("ovf_line_len", int'(dut.line_len_q), 1023);
    send_range(64, 0, 10, 704, NEVER);
    repeat (2) send_line(704, 64, 0, NEVER);

    // Asynchronous reset mid-line
    scanlines = 2'd1;
    repeat (3) send_line(100, 8, 1, NEVER);
    send_range(8, 1, 0, 50, NEVER);
    reset_n = 1'b0;
    #1;
    chk("amid_r_out", int'(r_out), 0);
    chk("amid_g_out", int'(g_out), 0);
    chk("amid_b_out", int'(b_out), 0);
    chk("amid_hs_out", int'(hs_out), 0);
    chk("amid_line_len", int'(dut.line_len_q), 0);
    repeat (5) tick();
    reset_n = 1'b1;
    send_range(8, 1, 50, 100, NEVER);
    repeat (4) send_line(100, 8, 0, NEVER);
    repeat (8) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
